// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - sequencer state encodings and opcode constants
package cpu_seq_pkg;

  localparam int SEQ_WIDTH = 32;

  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_BR   = 5'b01010;

  typedef enum logic [2:0] {
    SEQ_IDLE       = 3'd0,
    SEQ_FETCH      = 3'd1,
    SEQ_DECODE     = 3'd2,
    SEQ_EXECUTE    = 3'd3,
    SEQ_WRITE_BACK = 3'd4,
    SEQ_HALTED     = 3'd5
  } seq_state_e;

  function automatic logic [4:0] opcode_of(input logic [SEQ_WIDTH-1:0] word);
    return word[31:27];
  endfunction

endpackage

// File: rtl/cpu_seq.sv
// rtl/cpu_seq.sv - handshaked multi-cycle control sequencer for the nemesys core
module cpu_seq
  import cpu_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] ir,
  input  logic             ex_busy,
  output logic             pc_enable,
  output logic             reg_write_enable,
  output logic [2:0]       state_out,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  seq_state_e       r_state;
  logic [WIDTH-1:0] r_ir;
  logic [CNT_W-1:0] r_retired;
  logic             r_step_mode;
  logic [4:0]       w_opcode;

  assign w_opcode = opcode_of(r_ir);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEQ_IDLE;
      r_ir        <= '0;
      r_retired   <= '0;
      r_step_mode <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          // step wins over run so a debugger can single-step a running core
          if (step) begin
            r_step_mode <= 1'b1;
            r_state     <= SEQ_FETCH;
          end else if (run) begin
            r_step_mode <= 1'b0;
            r_state     <= SEQ_FETCH;
          end
        end
        SEQ_FETCH: begin
          if (imem_ack) begin
            r_ir    <= inst;
            r_state <= SEQ_DECODE;
          end
        end
        SEQ_DECODE:
          r_state <= (w_opcode == OP_HALT) ? SEQ_HALTED : SEQ_EXECUTE;
        SEQ_EXECUTE: begin
          if (!ex_busy) r_state <= SEQ_WRITE_BACK;
        end
        SEQ_WRITE_BACK: begin
          r_retired <= r_retired + CNT_W'(1);
          r_state   <= (r_step_mode || !run) ? SEQ_IDLE : SEQ_FETCH;
        end
        SEQ_HALTED:
          r_state <= SEQ_HALTED;
        default:
          r_state <= SEQ_IDLE;
      endcase
    end
  end

  // Strobes are pure state decodes so they can never outlive their state
  assign imem_req         = (r_state == SEQ_FETCH);
  assign pc_enable        = (r_state == SEQ_WRITE_BACK);
  assign reg_write_enable = (r_state == SEQ_WRITE_BACK) && (w_opcode != OP_BR);
  assign halted           = (r_state == SEQ_HALTED);
  assign state_out        = r_state;
  assign ir               = r_ir;
  assign retired          = r_retired;

endmodule

// File: tb/tb_cpu_seq.sv
// tb/tb_cpu_seq.sv - directed table-driven bench for cpu_seq
module tb_cpu_seq;

  localparam logic [31:0] W_ADD  = 32'h0800_0001;
  localparam logic [31:0] W_ADD2 = 32'h0800_BEEF;
  localparam logic [31:0] W_JUNK = 32'h1234_5678;
  localparam logic [31:0] W_BR   = 32'h5000_0123;
  localparam logic [31:0] W_HALT = 32'hF800_0000;

  localparam logic [2:0] S_IDLE = 3'd0, S_FE = 3'd1, S_DE = 3'd2,
                         S_EX = 3'd3, S_WB = 3'd4, S_HA = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1, run = 1'b0, step = 1'b0, imem_ack = 1'b0, ex_busy = 1'b0;
  logic [31:0] inst = '0;
  logic        imem_req, pc_enable, reg_write_enable, halted;
  logic [31:0] ir, retired;
  logic [2:0]  state_out;

  int total = 0;
  int bad   = 0;

  cpu_seq #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .imem_req(imem_req), .imem_ack(imem_ack), .inst(inst), .ir(ir),
    .ex_busy(ex_busy), .pc_enable(pc_enable), .reg_write_enable(reg_write_enable),
    .state_out(state_out), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, run, step, ack, busy;
    logic [31:0] inst;
    logic [2:0]  st;
    logic        req, pc, rwe, hlt;
    logic [31:0] ir;
    logic [31:0] ret;
  } vec_t;

  function automatic vec_t mk(input logic rst_i, run_i, step_i, ack_i, busy_i,
                              input logic [31:0] inst_i, input logic [2:0] st_i,
                              input logic req_i, pc_i, rwe_i, hlt_i,
                              input logic [31:0] ir_i, ret_i);
    vec_t v;
    v.rst = rst_i; v.run = run_i; v.step = step_i; v.ack = ack_i; v.busy = busy_i;
    v.inst = inst_i; v.st = st_i; v.req = req_i; v.pc = pc_i; v.rwe = rwe_i;
    v.hlt = hlt_i; v.ir = ir_i; v.ret = ret_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; run = v.run; step = v.step; imem_ack = v.ack;
    ex_busy = v.busy; inst = v.inst;
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 32'(state_out), 32'(v.st));
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(v.req));
    chk({tag, ".pc_enable"}, 32'(pc_enable), 32'(v.pc));
    chk({tag, ".reg_we"}, 32'(reg_write_enable), 32'(v.rwe));
    chk({tag, ".halted"}, 32'(halted), 32'(v.hlt));
    chk({tag, ".ir"}, ir, v.ir);
    chk({tag, ".retired"}, retired, v.ret);
  endtask

  vec_t tbl[$];

  initial begin
    // continuous run, zero-wait: pc_enable every 4th cycle, retired=3 after 12
    tbl.push_back(mk(1,0,0,0,0, W_ADD, S_IDLE,0,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,0,1,0, W_ADD, S_FE,  1,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,0,1,0, W_ADD, S_DE,  0,0,0,0, W_ADD, 0));
    tbl.push_back(mk(0,1,0,1,0, W_ADD, S_EX,  0,0,0,0, W_ADD, 0));
    tbl.push_back(mk(0,1,0,0,0, W_ADD, S_WB,  0,1,1,0, W_ADD, 0));
    tbl.push_back(mk(0,1,0,1,0, W_ADD, S_FE,  1,0,0,0, W_ADD, 1));
    tbl.push_back(mk(0,1,0,1,0, W_ADD, S_DE,  0,0,0,0, W_ADD, 1));
    tbl.push_back(mk(0,1,0,0,0, W_ADD, S_EX,  0,0,0,0, W_ADD, 1));
    tbl.push_back(mk(0,1,0,0,0, W_ADD, S_WB,  0,1,1,0, W_ADD, 1));
    tbl.push_back(mk(0,1,0,1,0, W_ADD, S_FE,  1,0,0,0, W_ADD, 2));
    tbl.push_back(mk(0,1,0,1,0, W_ADD, S_DE,  0,0,0,0, W_ADD, 2));
    tbl.push_back(mk(0,1,0,0,0, W_ADD, S_EX,  0,0,0,0, W_ADD, 2));
    tbl.push_back(mk(0,1,0,0,0, W_ADD, S_WB,  0,1,1,0, W_ADD, 2));
    tbl.push_back(mk(0,1,0,0,0, W_ADD, S_FE,  1,0,0,0, W_ADD, 3));
    // ack delayed 3 cycles, ex_busy held 2 cycles: WB 8 cycles after FETCH entry
    tbl.push_back(mk(1,1,0,0,0, W_JUNK, S_IDLE,0,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0, W_JUNK, S_FE,  1,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0, W_JUNK, S_FE,  1,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0, W_JUNK, S_FE,  1,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0, W_JUNK, S_FE,  1,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,0,1,0, W_ADD2, S_DE,  0,0,0,0, W_ADD2, 0));
    tbl.push_back(mk(0,1,0,0,1, W_JUNK, S_EX,  0,0,0,0, W_ADD2, 0));
    tbl.push_back(mk(0,1,0,0,1, W_JUNK, S_EX,  0,0,0,0, W_ADD2, 0));
    tbl.push_back(mk(0,1,0,0,1, W_JUNK, S_EX,  0,0,0,0, W_ADD2, 0));
    tbl.push_back(mk(0,1,0,0,0, W_JUNK, S_WB,  0,1,1,0, W_ADD2, 0));
    tbl.push_back(mk(0,1,0,0,0, W_JUNK, S_FE,  1,0,0,0, W_ADD2, 1));
    // reset in FETCH with ack in the same cycle: ack lost, everything cleared
    tbl.push_back(mk(1,1,0,1,0, W_ADD, S_IDLE,0,0,0,0, 0, 0));
    // step and run together with BR: one instruction, no reg write, back to IDLE
    tbl.push_back(mk(0,1,1,0,0, W_BR, S_FE,  1,0,0,0, 0, 0));
    tbl.push_back(mk(0,1,1,1,0, W_BR, S_DE,  0,0,0,0, W_BR, 0));
    tbl.push_back(mk(0,1,1,0,0, W_BR, S_EX,  0,0,0,0, W_BR, 0));
    tbl.push_back(mk(0,1,1,0,0, W_BR, S_WB,  0,1,0,0, W_BR, 0));
    tbl.push_back(mk(0,1,1,0,0, W_BR, S_IDLE,0,0,0,0, W_BR, 1));
    tbl.push_back(mk(0,0,0,1,0, W_BR, S_IDLE,0,0,0,0, W_BR, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // run dropped during a busy EXECUTE: instruction still retires, then IDLE
    apply(mk(1,0,0,0,0, W_ADD, S_IDLE,0,0,0,0, 0, 0), "rd_rst");
    apply(mk(0,1,0,0,0, W_ADD, S_FE,  1,0,0,0, 0, 0), "rd_fe");
    apply(mk(0,1,0,1,0, W_ADD, S_DE,  0,0,0,0, W_ADD, 0), "rd_de");
    apply(mk(0,1,0,0,1, W_ADD, S_EX,  0,0,0,0, W_ADD, 0), "rd_ex0");
    apply(mk(0,0,0,0,1, W_ADD, S_EX,  0,0,0,0, W_ADD, 0), "rd_ex1");
    apply(mk(0,0,0,0,0, W_ADD, S_WB,  0,1,1,0, W_ADD, 0), "rd_wb");
    apply(mk(0,0,0,1,0, W_ADD, S_IDLE,0,0,0,0, W_ADD, 1), "rd_idle");
    apply(mk(0,0,0,1,0, W_ADD, S_IDLE,0,0,0,0, W_ADD, 1), "rd_idle2");

    // HALT opcode: stops after DECODE, ignores run/step until reset
    apply(mk(1,0,0,0,0, W_HALT, S_IDLE,0,0,0,0, 0, 0), "h_rst");
    apply(mk(0,1,0,0,0, W_HALT, S_FE,  1,0,0,0, 0, 0), "h_fe");
    apply(mk(0,1,0,1,0, W_HALT, S_DE,  0,0,0,0, W_HALT, 0), "h_de");
    apply(mk(0,1,0,1,0, W_ADD,  S_HA,  0,0,0,1, W_HALT, 0), "h_ha");
    apply(mk(0,0,1,1,0, W_ADD,  S_HA,  0,0,0,1, W_HALT, 0), "h_step");
    apply(mk(0,1,1,0,0, W_ADD,  S_HA,  0,0,0,1, W_HALT, 0), "h_both");
    apply(mk(0,0,0,0,0, W_ADD,  S_HA,  0,0,0,1, W_HALT, 0), "h_quiet");
    apply(mk(1,1,0,0,0, W_ADD,  S_IDLE,0,0,0,0, 0, 0), "h_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
